// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M/RV64M multiply/divide unit (pipelined mul, radix-2 restoring div).
// Optional macro MULDIV_EARLY_OUT_EN: div-by-zero and signed overflow complete one cycle after accept.
module muldiv_unit #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enabled,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            completed,
    output logic [XLEN-1:0] rd
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_e;

    localparam int CW = $clog2(XLEN) + 1;
    localparam int PD = (MUL_LATENCY > 2) ? MUL_LATENCY - 2 : 0;
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] rd_q, rd_d;

    logic accept;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v,
                                            input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    function automatic logic is_corner(input logic [2:0] o,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
        return o[2] && ((b == '0) ||
               (!o[0] && (a == MINV) && (b == '1)));
    endfunction

    function automatic logic [XLEN-1:0] corner_res(input logic [2:0] o,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        if (b == '0) return o[1] ? a : '1;
        return o[1] ? '0 : MINV;
    endfunction

    assign busy      = (state_q == MUL) || (state_q == DIV);
    assign completed = (state_q == DONE);
    assign rd        = rd_q;
    assign accept    = enabled && !busy && !flush;

    // With single-cycle latency the product is formed from the live inputs.
    logic [2:0]        mop;
    logic [XLEN-1:0]   ma, mb;
    logic              ma_sgn, mb_sgn;
    logic [2*XLEN-1:0] max, mbx, prod;
    logic [XLEN-1:0]   mul_res, mul_out;

    assign mop    = (MUL_LATENCY == 1) ? op  : op_q;
    assign ma     = (MUL_LATENCY == 1) ? rs1 : a_q;
    assign mb     = (MUL_LATENCY == 1) ? rs2 : b_q;
    assign ma_sgn = (mop == 3'd1) || (mop == 3'd2);
    assign mb_sgn = (mop == 3'd1);
    assign max    = {{XLEN{ma_sgn & ma[XLEN-1]}}, ma};
    assign mbx    = {{XLEN{mb_sgn & mb[XLEN-1]}}, mb};
    assign prod   = max * mbx;
    assign mul_res = (mop == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    generate
        if (PD > 0) begin : g_pipe
            logic [XLEN-1:0] pipe_q [PD];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PD; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= mul_res;
                    for (int i = 1; i < PD; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign mul_out = pipe_q[PD-1];
        end else begin : g_nopipe
            assign mul_out = mul_res;
        end
    endgenerate

    logic [XLEN:0]   rem_sh, diff;
    logic            take;
    logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix, div_res;
    logic            sgn_op, neg_q, neg_r;

    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign take   = !diff[XLEN];
    assign rem_nx = take ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_nx = {quo_q[XLEN-2:0], take};

    // Signs are applied to the magnitudes only on the final iteration.
    assign sgn_op = !op_q[0];
    assign neg_q  = sgn_op && (a_q[XLEN-1] ^ b_q[XLEN-1]);
    assign neg_r  = sgn_op && a_q[XLEN-1];
    assign q_fix  = neg_q ? -quo_nx : quo_nx;
    assign r_fix  = neg_r ? -rem_nx : rem_nx;
    assign div_res = is_corner(op_q, a_q, b_q) ? corner_res(op_q, a_q, b_q)
                   : (op_q[1] ? r_fix : q_fix);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        rd_d    = rd_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    op_d = op;
                    a_d  = rs1;
                    b_d  = rs2;
                    if (!op[2]) begin
                        if (MUL_LATENCY == 1) begin
                            state_d = DONE;
                            rd_d    = mul_out;
                        end else begin
                            state_d = MUL;
                            cnt_d   = CW'(MUL_LATENCY - 2);
                        end
                    end else begin
                        state_d = DIV;
                        cnt_d   = CW'(XLEN - 1);
                        quo_d   = mag(rs1, !op[0]);
                        dvs_d   = mag(rs2, !op[0]);
                        rem_d   = '0;
`ifdef MULDIV_EARLY_OUT_EN
                        if (is_corner(op, rs1, rs2)) begin
                            state_d = DONE;
                            rd_d    = corner_res(op, rs1, rs2);
                        end
`endif
                    end
                end
            end
            MUL: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                    rd_d    = mul_out;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    quo_d = quo_nx;
                    rem_d = rem_nx;
                    if (cnt_q == '0) begin
                        state_d = DONE;
                        rd_d    = div_res;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit against an arithmetic reference model.
// Build with MULDIV_EARLY_OUT_EN defined to expect one-cycle corner-case divides.
module tb_muldiv_unit #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
);

    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    logic            clk = 1'b0;
    logic            rst;
    logic            enabled;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            completed;
    logic [XLEN-1:0] rd;

    muldiv_unit #(.XLEN(XLEN), .MUL_LATENCY(MUL_LATENCY)) dut (
        .clk(clk), .rst(rst), .enabled(enabled), .op(op),
        .rs1(rs1), .rs2(rs2), .flush(flush),
        .busy(busy), .completed(completed), .rd(rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] res;
        int              edge_no;
    } exp_t;

    exp_t            exp_q[$];
    int              ecnt  = 0;
    int              total = 0;
    int              bad   = 0;
    logic [XLEN-1:0] rd_model = '0;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string name, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b t=%0t", name, got, want, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_result(input logic [2:0] o,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic signed [2*XLEN+1:0] x, y, p;
        logic signed [XLEN-1:0]   sa, sbv;
        logic                     ovf;
        sa  = a;
        sbv = b;
        ovf = (a == MINV) && (b == '1);
        if (o < 3'd4) begin
            x = (o == 3'd1 || o == 3'd2) ? {{(XLEN+2){a[XLEN-1]}}, a}
                                         : {{(XLEN+2){1'b0}}, a};
            y = (o == 3'd1) ? {{(XLEN+2){b[XLEN-1]}}, b}
                            : {{(XLEN+2){1'b0}}, b};
            p = x * y;
            return (o == 3'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
        end
        case (o)
            3'd4: begin
                if (b == '0) return '1;
                if (ovf) return MINV;
                return sa / sbv;
            end
            3'd5: return (b == '0) ? '1 : a / b;
            3'd6: begin
                if (b == '0) return a;
                if (ovf) return '0;
                return sa % sbv;
            end
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
        if (o < 3'd4) return MUL_LATENCY;
`ifdef MULDIV_EARLY_OUT_EN
        if (b == '0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == MINV && b == '1) return 1;
`endif
        return XLEN + 1;
    endfunction

    function automatic logic [XLEN-1:0] rnd_val();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: return '0;
            1: return MINV;
            2: return '1;
            3: return XLEN'(1);
            4: return {{(XLEN-8){1'b0}}, r[7:0]};
            default: return r[XLEN-1:0];
        endcase
    endfunction

    // Monitor: pops the scoreboard on every completed pulse.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (completed) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_completed got=1 want=0 rd=%h", rd);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd", rd, e.res);
                    chk_int("latency_edge", ecnt, e.edge_no);
                    rd_model = e.res;
                end
            end else begin
                if (exp_q.size() > 0 && exp_q[0].edge_no < ecnt) begin
                    e = exp_q.pop_front();
                    total++;
                    bad++;
                    $display("FAIL missing_completed got=none want_edge=%0d", e.edge_no);
                end
                if (!busy) chk("rd_hold", rd, rd_model);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b);
        exp_t e;
        enabled = 1'b1;
        op      = o;
        rs1     = a;
        rs2     = b;
        e.res     = ref_result(o, a, b);
        e.edge_no = ecnt + ref_latency(o, a, b);
        exp_q.push_back(e);
    endtask

    task automatic wait_free(input bit junk);
        int guard = 0;
        while (busy && guard < 4 * XLEN + 20) begin
            enabled = junk;
            op      = 3'($urandom_range(0, 7));
            rs1     = rnd_val();
            rs2     = rnd_val();
            @(negedge clk);
            guard++;
        end
        enabled = 1'b0;
        if (busy) begin
            total++;
            bad++;
            $display("FAIL busy_timeout got=1 want=0");
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input bit junk);
        wait_free(junk);
        issue(o, a, b);
        @(negedge clk);
        enabled = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        enabled = 1'b0;
        flush   = 1'b0;
        op      = '0;
        rs1     = '0;
        rs2     = '0;
        repeat (2) @(negedge clk);
        chk_bit("reset_busy", busy, 1'b0);
        chk_bit("reset_completed", completed, 1'b0);
        chk("reset_rd", rd, '0);
        rst = 1'b0;
        @(negedge clk);

        run_op(3'd0, '1, XLEN'(2), 1'b0);
        run_op(3'd3, '1, XLEN'(2), 1'b0);
        run_op(3'd1, '1, XLEN'(2), 1'b0);
        run_op(3'd2, '1, XLEN'(2), 1'b0);
        run_op(3'd4, XLEN'(-7), XLEN'(2), 1'b0);
        run_op(3'd6, XLEN'(-7), XLEN'(2), 1'b0);
        run_op(3'd5, XLEN'(100), XLEN'(7), 1'b0);
        run_op(3'd7, XLEN'(100), XLEN'(7), 1'b0);
        run_op(3'd5, XLEN'(5), '0, 1'b0);
        run_op(3'd7, XLEN'(5), '0, 1'b0);
        run_op(3'd4, XLEN'(-7), '0, 1'b0);
        run_op(3'd6, XLEN'(-7), '0, 1'b0);
        run_op(3'd4, MINV, '1, 1'b0);
        run_op(3'd6, MINV, '1, 1'b0);

        // Flush on cycle 10 of a divide.
        wait_free(1'b0);
        issue(3'd4, XLEN'(1000), XLEN'(3));
        @(negedge clk);
        enabled = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(negedge clk);
        flush = 1'b0;
        chk_bit("flush_busy", busy, 1'b0);
        chk_bit("flush_completed", completed, 1'b0);
        chk("flush_rd", rd, rd_model);

        // Flush and enabled together: not accepted.
        wait_free(1'b0);
        enabled = 1'b1;
        flush   = 1'b1;
        op      = 3'd5;
        rs1     = XLEN'(9);
        rs2     = XLEN'(2);
        @(negedge clk);
        enabled = 1'b0;
        flush   = 1'b0;
        chk_bit("flush_en_busy", busy, 1'b0);
        @(negedge clk);
        chk_bit("flush_en_completed", completed, 1'b0);

        // Reset in the middle of a multiply.
        wait_free(1'b0);
        issue(3'd0, XLEN'(123), XLEN'(45));
        @(negedge clk);
        enabled  = 1'b0;
        rst      = 1'b1;
        exp_q.delete();
        rd_model = '0;
        @(negedge clk);
        chk_bit("midrst_busy", busy, 1'b0);
        chk_bit("midrst_completed", completed, 1'b0);
        chk("midrst_rd", rd, '0);
        rst = 1'b0;
        @(negedge clk);

        // Enabled held while busy is ignored; next op lands in the DONE cycle.
        run_op(3'd6, XLEN'(-100), XLEN'(7), 1'b0);
        run_op(3'd0, XLEN'(6), XLEN'(7), 1'b1);
        run_op(3'd1, MINV, MINV, 1'b0);

        for (int i = 0; i < 150; i++) begin
            run_op(3'($urandom_range(0, 7)), rnd_val(), rnd_val(),
                   1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        begin
            int g = 0;
            while (exp_q.size() > 0 && g < 4 * XLEN + 20) begin
                @(negedge clk);
                g++;
            end
            if (exp_q.size() > 0) begin
                total++;
                bad++;
                $display("FAIL drain_timeout got=%0d want=0", exp_q.size());
            end
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
